// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between NREQ requesters, with a
// single-entry response buffer. Optional requester lock under `ALU_ARB_LOCK_EN`.
module alu_arbiter #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned SEL_W  = 4,
  localparam int unsigned IDW   = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NREQ-1:0]        req_lock,
`endif
  input  logic [NREQ*DATA_W-1:0] req_op1,
  input  logic [NREQ*DATA_W-1:0] req_op2,
  input  logic [NREQ*SEL_W-1:0]  req_sel,
  output logic [DATA_W-1:0]      alu_op1,
  output logic [DATA_W-1:0]      alu_op2,
  output logic [SEL_W-1:0]       alu_sel,
  input  logic [DATA_W-1:0]      alu_result,
  input  logic                   alu_zero,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [DATA_W-1:0]      rsp_result,
  output logic                   rsp_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [IDW-1:0]    prio_q;
  logic [IDW-1:0]    id_q;
  logic [DATA_W-1:0] op1_q, op2_q;
  logic [SEL_W-1:0]  sel_q;
  logic              rsp_valid_q, rsp_zero_q;
  logic [IDW-1:0]    rsp_id_q;
  logic [DATA_W-1:0] rsp_result_q;

  logic [NREQ-1:0]   eligible;
  logic              grant_found;
  logic [IDW-1:0]    grant_id;
  logic              can_accept;
  logic              accept;
  logic [DATA_W-1:0] sel_op1, sel_op2;
  logic [SEL_W-1:0]  sel_sel;

`ifdef ALU_ARB_LOCK_EN
  logic            lock_q;
  logic [IDW-1:0]  lock_id_q;
  logic [NREQ-1:0] lock_mask;

  // While locked only the lock holder is eligible; everyone else stalls.
  always_comb begin
    lock_mask = '1;
    if (lock_q) begin
      lock_mask = '0;
      lock_mask[lock_id_q] = 1'b1;
    end
  end

  assign eligible = req_valid & lock_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else if (accept) begin
      lock_q    <= req_lock[grant_id];
      lock_id_q <= grant_id;
    end
  end
`else
  assign eligible = req_valid;
`endif

  // Search starts at prio_q, which holds (last granted + 1) mod NREQ.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(prio_q) + k) % NREQ;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_id    = IDW'(idx);
      end
    end
  end

  always_comb begin
    sel_op1 = '0;
    sel_op2 = '0;
    sel_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_op1 = req_op1[i*DATA_W +: DATA_W];
        sel_op2 = req_op2[i*DATA_W +: DATA_W];
        sel_sel = req_sel[i*SEL_W +: SEL_W];
      end
    end
  end

  assign can_accept = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
  assign accept     = can_accept && grant_found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = accept ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prio_q       <= '0;
      id_q         <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      sel_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op1_q  <= sel_op1;
        op2_q  <= sel_op2;
        sel_q  <= sel_sel;
        id_q   <= grant_id;
        prio_q <= IDW'((32'(grant_id) + 1) % NREQ);
      end
      if (state_q == EXEC) begin
        rsp_valid_q  <= 1'b1;
        rsp_id_q     <= id_q;
        rsp_result_q <= alu_result;
        rsp_zero_q   <= alu_zero;
      end else if ((state_q == RESP) && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign alu_sel    = sel_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;

endmodule
